// File: rtl/sfu_pwl_lanes.sv
// rtl/sfu_pwl_lanes.sv - multi-lane piecewise-linear special-function unit
//
// Evaluates y = sat(icpt + ((slope * xc) >>> FRAC_W)) on LANES lanes in parallel.
// The slope and intercept come from a programmable per-mode segment LUT.
// Pipeline: S1 clamp+index, S2 LUT read, S3 multiply-add-saturate into the output register.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_mode selects the LUT bank, in_data packs the lanes
//   out_valid/out_ready  output handshake; out_data uses the same lane packing as in_data
//   cfg_we, cfg_mode,    LUT write port, one {slope, icpt} entry per strobe
//   cfg_idx, cfg_slope,
//   cfg_icpt
//   busy                 any pipeline stage holds a valid beat
module sfu_pwl_lanes #(
   parameter int LANES     = 4,
   parameter int DATA_W    = 16,
   parameter int FRAC_W    = 8,
   parameter int SEG_BITS  = 5,
   parameter int SEG_SHIFT = 7,
   parameter int MODE_W    = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [MODE_W-1:0]         in_mode,
   input  logic [LANES*DATA_W-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data,
   input  logic                      cfg_we,
   input  logic [MODE_W-1:0]         cfg_mode,
   input  logic [SEG_BITS-1:0]       cfg_idx,
   input  logic [DATA_W-1:0]         cfg_slope,
   input  logic [DATA_W-1:0]         cfg_icpt,
   output logic                      busy
);

   localparam int ADDR_W  = MODE_W + SEG_BITS;
   localparam int ENTRIES = 1 << ADDR_W;
   localparam int PW      = 2 * DATA_W;
   localparam int X_TOP   = SEG_SHIFT + SEG_BITS - 1;

   localparam logic signed [DATA_W-1:0] XMAX = DATA_W'((1 << X_TOP) - 1);
   localparam logic signed [DATA_W-1:0] XMIN = DATA_W'(-(1 << X_TOP));
   localparam logic signed [PW:0]       YMAX = (PW+1)'((1 << (DATA_W-1)) - 1);
   localparam logic signed [PW:0]       YMIN = (PW+1)'(-(1 << (DATA_W-1)));
   localparam logic [SEG_BITS-1:0]      IDX_MSB = SEG_BITS'(1) << (SEG_BITS-1);

   // Shared LUT, addressed as {mode, segment}
   logic [DATA_W-1:0] lut_slope [ENTRIES];
   logic [DATA_W-1:0] lut_icpt  [ENTRIES];

   // Stage registers
   logic                     s1_valid;
   logic [MODE_W-1:0]        s1_mode;
   logic signed [DATA_W-1:0] s1_xc  [LANES];
   logic [SEG_BITS-1:0]      s1_idx [LANES];

   logic                     s2_valid;
   logic signed [DATA_W-1:0] s2_xc    [LANES];
   logic signed [DATA_W-1:0] s2_slope [LANES];
   logic signed [DATA_W-1:0] s2_icpt  [LANES];

   // Single global stall: every stage moves only when the output slot is free
   logic advance;
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance;
   assign busy     = s1_valid | s2_valid | out_valid;

   // S1: clamp into the LUT's domain, then take the segment bits as offset binary
   logic signed [DATA_W-1:0] s1_xc_d  [LANES];
   logic [SEG_BITS-1:0]      s1_idx_d [LANES];
   logic signed [DATA_W-1:0] x_l;
   logic signed [DATA_W-1:0] xc_l;

   always_comb begin
      x_l  = '0;
      xc_l = '0;
      for (int i = 0; i < LANES; i++) begin
         x_l = in_data[i*DATA_W +: DATA_W];
         if (x_l > XMAX)
            xc_l = XMAX;
         else if (x_l < XMIN)
            xc_l = XMIN;
         else
            xc_l = x_l;
         s1_xc_d[i]  = xc_l;
         s1_idx_d[i] = xc_l[X_TOP:SEG_SHIFT] ^ IDX_MSB;
      end
   end

   // S3: full-width product, floor shift, widened add, saturate
   logic [LANES*DATA_W-1:0]  y_d;
   logic signed [PW-1:0]     prod;
   logic signed [PW-1:0]     shifted;
   logic signed [PW:0]       sum;

   always_comb begin
      y_d     = '0;
      prod    = '0;
      shifted = '0;
      sum     = '0;
      for (int i = 0; i < LANES; i++) begin
         prod    = PW'(s2_slope[i]) * PW'(s2_xc[i]);
         shifted = prod >>> FRAC_W;
         sum     = (PW+1)'(shifted) + (PW+1)'(s2_icpt[i]);
         if (sum > YMAX)
            y_d[i*DATA_W +: DATA_W] = YMAX[DATA_W-1:0];
         else if (sum < YMIN)
            y_d[i*DATA_W +: DATA_W] = YMIN[DATA_W-1:0];
         else
            y_d[i*DATA_W +: DATA_W] = sum[DATA_W-1:0];
      end
   end

   // Valid chain and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid)
            out_data <= y_d;
      end
   end

   // Datapath registers only load behind a valid beat; their contents are
   // never observed without the matching valid bit.
   always_ff @(posedge clk) begin
      if (advance && in_valid) begin
         s1_mode <= in_mode;
         for (int i = 0; i < LANES; i++) begin
            s1_xc[i]  <= s1_xc_d[i];
            s1_idx[i] <= s1_idx_d[i];
         end
      end
      if (advance && s1_valid) begin
         for (int i = 0; i < LANES; i++) begin
            s2_xc[i]    <= s1_xc[i];
            s2_slope[i] <= lut_slope[{s1_mode, s1_idx[i]}];
            s2_icpt[i]  <= lut_icpt[{s1_mode, s1_idx[i]}];
         end
      end
   end

   // LUT write port; a same-edge S2 read captures the pre-write entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < ENTRIES; e++) begin
            lut_slope[e] <= '0;
            lut_icpt[e]  <= '0;
         end
      end else if (cfg_we) begin
         lut_slope[{cfg_mode, cfg_idx}] <= cfg_slope;
         lut_icpt[{cfg_mode, cfg_idx}]  <= cfg_icpt;
      end
   end

endmodule

// File: tb/tb_sfu_pwl_lanes.sv
// tb/tb_sfu_pwl_lanes.sv - scoreboard bench for sfu_pwl_lanes
module tb_sfu_pwl_lanes;

   localparam int LANES = 4;
   localparam int DW    = 16;
   localparam int BW    = LANES * DW;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [0:0]    in_mode;
   logic [BW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic          cfg_we;
   logic [0:0]    cfg_mode;
   logic [4:0]    cfg_idx;
   logic [DW-1:0] cfg_slope;
   logic [DW-1:0] cfg_icpt;
   logic          busy;

   sfu_pwl_lanes dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cfg_we    (cfg_we),
      .cfg_mode  (cfg_mode),
      .cfg_idx   (cfg_idx),
      .cfg_slope (cfg_slope),
      .cfg_icpt  (cfg_icpt),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference LUT and arithmetic model
   logic signed [DW-1:0] m_slope [2][32];
   logic signed [DW-1:0] m_icpt  [2][32];
   logic [BW-1:0]        sb [$];

   function automatic logic [DW-1:0] model_lane(input int mode, input logic [DW-1:0] x);
      int     xs;
      int     xc;
      int     idx;
      longint p;
      longint s;
      xs = int'($signed(x));
      xc = (xs > 2047) ? 2047 : ((xs < -2048) ? -2048 : xs);
      idx = (xc + 2048) / 128;
      p = longint'(m_slope[mode][idx]) * longint'(xc);
      s = (p >>> 8) + longint'(m_icpt[mode][idx]);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return DW'(s);
   endfunction

   function automatic logic [BW-1:0] model_beat(input int mode, input logic [BW-1:0] d);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++)
         r[i*DW +: DW] = model_lane(mode, d[i*DW +: DW]);
      return r;
   endfunction

   function automatic void model_clear();
      for (int m = 0; m < 2; m++)
         for (int e = 0; e < 32; e++) begin
            m_slope[m][e] = '0;
            m_icpt[m][e]  = '0;
         end
   endfunction

   // All driving tasks start and end 1 time unit after a rising edge.
   task automatic cfg_write(input int mode, input int idx, input logic [DW-1:0] sl, input logic [DW-1:0] ic);
      cfg_we    = 1'b1;
      cfg_mode  = 1'(mode);
      cfg_idx   = 5'(idx);
      cfg_slope = sl;
      cfg_icpt  = ic;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      m_slope[mode][idx] = sl;
      m_icpt[mode][idx]  = ic;
   endtask

   task automatic send(input int mode, input logic [BW-1:0] d, input logic [BW-1:0] exp);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_mode  = 1'(mode);
      in_data  = d;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            sb.push_back(exp);
         end
         @(posedge clk);
         #1;
      end
      if (!acc) check_eq("send_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clk);
      #1;
      check_eq("drain_empty", BW'(sb.size()), 0);
   endtask

   // out_ready pattern generator: 0 = hold, 1 = toggle each cycle, 2 = random
   int bp_mode = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode == 1) out_ready = ~out_ready;
         else if (bp_mode == 2) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Output monitor: scoreboard compare, stall stability, in_ready relation
   bit            prev_stall = 1'b0;
   logic [BW-1:0] prev_data;
   int            out_count = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check_eq("in_ready_rule", BW'(in_ready), BW'(!(out_valid && !out_ready)));
            if (prev_stall) begin
               check_eq("stall_valid", BW'(out_valid), 1);
               check_eq("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
               out_count++;
               if (sb.size() == 0)
                  check_eq("unexpected_out", out_data, 'x);
               else
                  check_eq("out_data", out_data, sb.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BW-1:0] d;
      int            lat;
      int            seen;
      int            md;

      rst_n = 1'b0; in_valid = 1'b0; in_mode = '0; in_data = '0; out_ready = 1'b1;
      cfg_we = 1'b0; cfg_mode = '0; cfg_idx = '0; cfg_slope = '0; cfg_icpt = '0;
      model_clear();
      #12;
      check_eq("rst_out_valid", BW'(out_valid), 0);
      check_eq("rst_busy", BW'(busy), 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_in_ready", BW'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Identity bank for mode 0
      for (int e = 0; e < 32; e++) cfg_write(0, e, 16'h0100, 16'h0000);

      // Identity and latency
      send(0, {16'hFFFF, 16'h0040, 16'hFF00, 16'h0180}, {16'hFFFF, 16'h0040, 16'hFF00, 16'h0180});
      in_valid = 1'b0;
      lat = 1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (out_valid) break;
         lat++;
      end
      check_eq("latency", BW'(lat), 3);
      @(posedge clk);
      #1;

      // Clamp
      send(0, {16'hF800, 16'h07FF, 16'h8000, 16'h7FFF}, {16'hF800, 16'h07FF, 16'hF800, 16'h07FF});
      in_valid = 1'b0;
      drain();

      // Saturation at both rails
      cfg_write(0, 31, 16'h7FFF, 16'h7FFF);
      cfg_write(0, 0, 16'h7FFF, 16'h8000);
      send(0, {16'h0000, 16'h7FFF, 16'hF800, 16'h07FF}, {16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF});
      in_valid = 1'b0;
      drain();

      // LUT write racing an S2 read: first beat sees old entry, second the new one
      send(1, 64'h0, 64'h0);
      cfg_we = 1'b1; cfg_mode = 1'b1; cfg_idx = 5'd16; cfg_slope = 16'h0000; cfg_icpt = 16'h0100;
      send(1, 64'h0, {4{16'h0100}});
      cfg_we = 1'b0;
      m_slope[1][16] = 16'h0000;
      m_icpt[1][16]  = 16'h0100;
      in_valid = 1'b0;
      drain();

      // Random bank for mode 1, then mixed-mode back-to-back beats with random backpressure
      for (int e = 0; e < 32; e++) cfg_write(1, e, 16'($urandom), 16'($urandom));
      bp_mode = 2;
      for (int b = 0; b < 16; b++) begin
         d  = {$urandom, $urandom};
         md = $urandom_range(0, 1);
         send(md, d, model_beat(md, d));
      end
      in_valid = 1'b0;
      bp_mode = 0;
      out_ready = 1'b1;
      drain();

      // Ten back-to-back beats under 1010... backpressure
      out_ready = 1'b1;
      bp_mode = 1;
      seen = out_count;
      for (int b = 0; b < 10; b++) begin
         d = {16'(b * 300 - 1500), 16'(-b * 97), 16'($urandom), 16'(b * 211)};
         send(b % 2, d, model_beat(b % 2, d));
      end
      in_valid = 1'b0;
      bp_mode = 0;
      out_ready = 1'b1;
      drain();
      check_eq("bp_count", BW'(out_count - seen), 10);

      // Reset with three beats in flight
      send(0, 64'h0100_0100_0100_0100, model_beat(0, 64'h0100_0100_0100_0100));
      send(1, 64'h0200_0200_0200_0200, model_beat(1, 64'h0200_0200_0200_0200));
      send(0, 64'h0300_0300_0300_0300, model_beat(0, 64'h0300_0300_0300_0300));
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", BW'(out_valid), 0);
      check_eq("midrst_busy", BW'(busy), 0);
      check_eq("midrst_out_data", out_data, 0);
      sb.delete();
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_eq("post_rst_outputs", BW'(seen), 0);
      check_eq("post_rst_in_ready", BW'(in_ready), 1);
      @(posedge clk);
      #1;
      send(0, 64'h0180_FF00_1234_8000, 64'h0);
      send(1, 64'h7FFF_0000_0555_F000, 64'h0);
      in_valid = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sfu_pwl_lanes.md
SFU_PWL_LANES -- requirements
Module: sfu_pwl_lanes

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel lanes sharing one mode and one handshake.
REQ-002 SHALL have parameter DATA_W, default 16, signed two's-complement fixed-point width of x, y, slope and intercept.
REQ-003 SHALL have parameter FRAC_W, default 8, fractional bits of every data word.
REQ-004 SHALL have parameter SEG_BITS, default 5, log2 of segments per function (2^SEG_BITS entries per mode).
REQ-005 SHALL have parameter SEG_SHIFT, default 7, LSB position of the segment index inside x.
REQ-006 SHALL have parameter MODE_W, default 1, so there are 2^MODE_W independent LUT banks (e.g. GELU, SiLU).
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port in_valid, input, 1 bit, input beat present.
REQ-010 SHALL have port in_ready, output, 1 bit, block accepts the input beat this cycle.
REQ-011 SHALL have port in_mode, input, MODE_W bits, LUT bank for the beat.
REQ-012 SHALL have port in_data, input, LANES*DATA_W bits, lane i at [i*DATA_W +: DATA_W].
REQ-013 SHALL have port out_valid, output, 1 bit, result beat present.
REQ-014 SHALL have port out_ready, input, 1 bit, downstream accepts the result.
REQ-015 SHALL have port out_data, output, LANES*DATA_W bits, same lane packing as in_data.
REQ-016 SHALL have port cfg_we, input, 1 bit, LUT write strobe.
REQ-017 SHALL have port cfg_mode, input, MODE_W bits, bank to write.
REQ-018 SHALL have port cfg_idx, input, SEG_BITS bits, entry to write.
REQ-019 SHALL have ports cfg_slope and cfg_icpt, inputs, DATA_W bits each, entry contents.
REQ-020 SHALL have port busy, output, 1 bit, high when any pipeline stage holds a valid beat.

Function
REQ-021 SHALL be a 3-stage pipeline: S1 clamp+index, S2 LUT read, S3 multiply-add-saturate into the output register; latency exactly 3 cycles from acceptance to out_valid with out_ready held high.
REQ-022 SHALL accept a beat when in_valid && in_ready; in_ready = !(out_valid && !out_ready) (global stall; all stages hold when stalled).
REQ-023 SHALL sustain one beat per cycle with out_ready high; no beat dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL clamp each lane x to [XMIN, XMAX], XMIN = -2^(SEG_SHIFT+SEG_BITS-1), XMAX = 2^(SEG_SHIFT+SEG_BITS-1)-1.
REQ-026 SHALL form index = clamped x[SEG_SHIFT+SEG_BITS-1:SEG_SHIFT] with the MSB inverted (offset binary; index 0 = most negative segment).
REQ-027 SHALL compute y = sat(icpt + ((slope * xc) >>> FRAC_W)): full 2*DATA_W signed product, arithmetic shift (truncate toward -inf), sign-extended add, saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-028 SHALL provide per-lane independent LUT read ports over one shared register-array LUT (2^MODE_W * 2^SEG_BITS entries of {slope, icpt}).
REQ-029 SHALL apply a cfg_we write at the clock edge; a beat performing its S2 read in the write cycle sees the old entry, later reads see the new one.
REQ-030 SHALL accept cfg writes at any time, including during stalls, without affecting handshake.
REQ-031 SHALL carry in_mode with the beat; mode changes between consecutive beats need no bubble.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear all stage valids, out_valid=0, out_data=0, busy=0, all LUT entries=0; in_ready=1 after reset.
REQ-033 SHALL discard beats in flight when reset asserts mid-operation; no output appears for them after release.

Verification
REQ-034 Identity: all mode-0 entries slope=0x0100 icpt=0; x=0x0180 lane0, 0xFF00 lane1 -> out 0x0180, 0xFF00 exactly 3 cycles later.
REQ-035 Clamp: same LUT, x=0x7FFF and 0x8000 -> out 0x07FF and 0xF800.
REQ-036 Saturation: entry idx 31 slope=0x7FFF icpt=0x7FFF, x=0x07FF -> 0x7FFF; idx 0 slope=0x7FFF icpt=0x8000, x=0xF800 -> 0x8000.
REQ-037 Backpressure: 10 back-to-back beats, out_ready toggling 1010..., -> all 10 results in order, stable while stalled, in_ready low exactly when out_valid && !out_ready.
REQ-038 Mode/cfg race: mode1 idx 16 icpt=0x0100 written in same cycle beat x=0 mode1 is in S2 -> old result 0x0000; next beat -> 0x0100.
REQ-039 Reset mid-stream: assert rst_n low with 3 beats in flight -> out_valid=0, busy=0 immediately; no outputs after release; LUT reads return 0.
